// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the data_mem port shared by data_mem_arbiter.
// slave is the arbiter's view; master is the requesters plus memory side.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [31:0]       p0_wdata;
    logic [3:0]        p0_sign_mask;
    logic              p0_ack;
    logic [31:0]       p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [31:0]       p1_wdata;
    logic [3:0]        p1_sign_mask;
    logic              p1_ack;
    logic [31:0]       p1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data;
    logic              mem_memread;
    logic              mem_memwrite;
    logic [3:0]        mem_sign_mask;
    logic [31:0]       mem_read_data;
    logic              mem_stall;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_sign_mask,
        output p0_ack, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_sign_mask,
        output p1_ack, p1_rdata,
        output mem_addr, mem_write_data, mem_memread, mem_memwrite, mem_sign_mask,
        input  mem_read_data, mem_stall
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_sign_mask,
        input  p0_ack, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_sign_mask,
        input  p1_ack, p1_rdata,
        input  mem_addr, mem_write_data, mem_memread, mem_memwrite, mem_sign_mask,
        output mem_read_data, mem_stall
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data_mem port between the CPU (port 0) and debug/DMA (port 1).
// One access in flight; ISSUE/WAIT/RESP sequencing covers read latency and write stall.
module data_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1,
    parameter int WR_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    data_mem_arbiter_if.slave bus,
    output logic              busy,
    output logic              grant_id
);
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic              last_grant;
    logic              grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        mask_q;
    logic [CNT_W-1:0]  cnt;
    logic              memread_q;
    logic              memwrite_q;
    logic              ack0_q;
    logic              ack1_q;
    logic [31:0]       rdata0_q;
    logic [31:0]       rdata1_q;

    logic              any_req;
    logic              pick;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_addr;
    logic [31:0]       pick_wdata;
    logic [3:0]        pick_mask;
    logic [31:0]       resp_data;

    // On a tie the port that did not win last time gets the memory.
    always_comb begin
        any_req = bus.p0_req | bus.p1_req;
        pick    = 1'b0;
        if (bus.p0_req && bus.p1_req) begin
            pick = ~last_grant;
        end else if (bus.p1_req) begin
            pick = 1'b1;
        end
        pick_we    = pick ? bus.p1_we        : bus.p0_we;
        pick_addr  = pick ? bus.p1_addr      : bus.p0_addr;
        pick_wdata = pick ? bus.p1_wdata     : bus.p0_wdata;
        pick_mask  = pick ? bus.p1_sign_mask : bus.p0_sign_mask;
        resp_data  = we_q ? 32'h0 : bus.mem_read_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            cnt        <= '0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q    <= pick;
                        last_grant <= pick;
                        we_q       <= pick_we;
                        addr_q     <= pick_addr;
                        wdata_q    <= pick_wdata;
                        mask_q     <= pick_mask;
                        memread_q  <= ~pick_we;
                        memwrite_q <= pick_we;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= we_q ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    // Counter parks at zero while the memory keeps stalling.
                    if ((cnt <= CNT_W'(1)) && !bus.mem_stall) begin
                        state <= RESP;
                        if (grant_q) begin
                            ack1_q   <= 1'b1;
                            rdata1_q <= resp_data;
                        end else begin
                            ack0_q   <= 1'b1;
                            rdata0_q <= resp_data;
                        end
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr       = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.mem_sign_mask  = mask_q;
    assign bus.mem_memread    = memread_q;
    assign bus.mem_memwrite   = memwrite_q;
    assign bus.p0_ack         = ack0_q;
    assign bus.p1_ack         = ack1_q;
    assign bus.p0_rdata       = rdata0_q;
    assign bus.p1_rdata       = rdata1_q;
    assign busy               = (state != IDLE);
    assign grant_id           = grant_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: requester tasks queue expected responses,
// a monitor plays the memory and checks every strobe and ack against them.
module tb_data_mem_arbiter;
    localparam int RD_LAT = 1;
    localparam int WR_LAT = 2;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } op_t;

    logic clk;
    logic reset_n;
    logic busy;
    logic grant_id;

    data_mem_arbiter_if #(.ADDR_W(32)) tb_if ();

    data_mem_arbiter #(.ADDR_W(32), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (tb_if),
        .busy     (busy),
        .grant_id (grant_id)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_model [256];
    logic [31:0] shadow    [256];
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    int          ack_log [$];
    op_t         pend   [2];
    bit          pend_v [2];
    int          stall_left = 0;
    int          stall_req  = 0;
    bit          rand_stall = 0;
    int          strobe_count = 0;
    int          p1_ack_count = 0;
    bit          prev_strobe = 0;

    assign tb_if.mem_read_data = mem_model[tb_if.mem_addr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // One requester access: queue the expected response, hold req until ack, drop it the cycle after.
    task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] mask, output int lat);
        op_t         op;
        logic [31:0] exp;
        bit          acked;
        op.we = we; op.addr = addr; op.wdata = wdata; op.mask = mask;
        @(posedge clk); #1;
        if (we) begin
            exp = 32'h0;
            shadow[addr[7:0]] = wdata;
        end else begin
            exp = shadow[addr[7:0]];
        end
        pend[port]   = op;
        pend_v[port] = 1'b1;
        if (port == 0) begin
            exp_q0.push_back(exp);
            tb_if.p0_we = we; tb_if.p0_addr = addr; tb_if.p0_wdata = wdata; tb_if.p0_sign_mask = mask;
            tb_if.p0_req = 1'b1;
        end else begin
            exp_q1.push_back(exp);
            tb_if.p1_we = we; tb_if.p1_addr = addr; tb_if.p1_wdata = wdata; tb_if.p1_sign_mask = mask;
            tb_if.p1_req = 1'b1;
        end
        lat = 0;
        acked = 1'b0;
        while (!acked && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            acked = (port == 0) ? tb_if.p0_ack : tb_if.p1_ack;
        end
        if (!acked) checkOutput("ack_timeout", 32'(acked), 32'd1);
        @(posedge clk); #1;
        if (port == 0) begin
            tb_if.p0_req = 1'b0; tb_if.p0_addr = $urandom; tb_if.p0_wdata = $urandom;
        end else begin
            tb_if.p1_req = 1'b0; tb_if.p1_addr = $urandom; tb_if.p1_wdata = $urandom;
        end
    endtask

    // Monitor plus memory model: writes land on the strobe, stall follows each write strobe.
    always begin
        bit strobe;
        bit matched;
        int owner;
        @(posedge clk); #1;
        tb_if.mem_stall = (stall_left > 0);
        if (stall_left > 0) stall_left--;
        if (tb_if.p0_ack || tb_if.p1_ack) begin
            checkOutput("ack_exclusive", 32'(tb_if.p0_ack & tb_if.p1_ack), 32'd0);
            if (tb_if.p0_ack) begin
                ack_log.push_back(0);
                if (exp_q0.size() == 0) checkOutput("p0_unexpected_ack", 32'(tb_if.p0_ack), 32'd0);
                else checkOutput("p0_rdata", tb_if.p0_rdata, exp_q0.pop_front());
            end
            if (tb_if.p1_ack) begin
                ack_log.push_back(1);
                p1_ack_count++;
                if (exp_q1.size() == 0) checkOutput("p1_unexpected_ack", 32'(tb_if.p1_ack), 32'd0);
                else checkOutput("p1_rdata", tb_if.p1_rdata, exp_q1.pop_front());
            end
        end
        strobe = tb_if.mem_memread | tb_if.mem_memwrite;
        if (strobe) begin
            strobe_count++;
            checkOutput("strobe_exclusive", 32'(tb_if.mem_memread & tb_if.mem_memwrite), 32'd0);
            checkOutput("strobe_single_cycle", 32'(prev_strobe), 32'd0);
            matched = 1'b0;
            owner = 0;
            for (int p = 0; p < 2; p++) begin
                if (!matched && pend_v[p] && pend[p].we == tb_if.mem_memwrite &&
                    pend[p].addr == tb_if.mem_addr && pend[p].wdata == tb_if.mem_write_data &&
                    pend[p].mask == tb_if.mem_sign_mask) begin
                    matched = 1'b1;
                    owner = p;
                    pend_v[p] = 1'b0;
                end
            end
            checkOutput("strobe_fields", 32'(matched), 32'd1);
            if (matched) checkOutput("grant_id", 32'(grant_id), 32'(owner));
            if (tb_if.mem_memwrite) begin
                mem_model[tb_if.mem_addr[7:0]] = tb_if.mem_write_data;
                stall_left = rand_stall ? int'($urandom_range(0, 5)) : stall_req;
            end
        end
        prev_strobe = strobe;
    end

    initial begin
        int lat0, lat1, s0, a0;
        $display("[TB] start");
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = 32'hA5A50000 | 32'(i);
            shadow[i]    = 32'hA5A50000 | 32'(i);
        end
        pend_v[0] = 1'b0; pend_v[1] = 1'b0;
        tb_if.p0_req = 0; tb_if.p0_we = 0; tb_if.p0_addr = 0; tb_if.p0_wdata = 0; tb_if.p0_sign_mask = 0;
        tb_if.p1_req = 0; tb_if.p1_we = 0; tb_if.p1_addr = 0; tb_if.p1_wdata = 0; tb_if.p1_sign_mask = 0;
        tb_if.mem_stall = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_acks", {30'd0, tb_if.p1_ack, tb_if.p0_ack}, 32'd0);
        checkOutput("reset_strobes", {30'd0, tb_if.mem_memwrite, tb_if.mem_memread}, 32'd0);
        checkOutput("reset_mem_addr", tb_if.mem_addr, 32'd0);
        checkOutput("reset_mem_wdata", tb_if.mem_write_data, 32'd0);
        checkOutput("reset_mem_mask", 32'(tb_if.mem_sign_mask), 32'd0);
        checkOutput("reset_grant_id", 32'(grant_id), 32'd0);
        checkOutput("reset_rdata", tb_if.p0_rdata | tb_if.p1_rdata, 32'd0);
        reset_n = 1'b1;

        // Test 1: p0 load, ack in cycle 2+RD_LAT.
        mem_model[8'h10] = 32'hDEADBEEF;
        shadow[8'h10]    = 32'hDEADBEEF;
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h2, lat0);
        checkOutput("t1_read_latency", 32'(lat0), 32'(2 + RD_LAT));

        // Test 2: p1 store, ack in cycle 2+WR_LAT.
        s0 = strobe_count;
        applyStimulus(1, 1'b1, 32'h20, 32'h12345678, 4'hF, lat1);
        checkOutput("t2_write_latency", 32'(lat1), 32'(2 + WR_LAT));
        checkOutput("t2_strobe_count", 32'(strobe_count - s0), 32'd1);
        checkOutput("t2_mem_written", mem_model[8'h20], 32'h12345678);

        // Test 3: simultaneous requests alternate, p0 first since p1 won last.
        ack_log.delete();
        for (int r = 0; r < 4; r++) begin
            fork
                applyStimulus(0, 1'b0, 32'h10 + 32'(r * 4), 32'h0, 4'h1, lat0);
                applyStimulus(1, 1'b0, 32'h90 + 32'(r * 4), 32'h0, 4'h1, lat1);
            join
        end
        checkOutput("t3_grant_count", 32'(ack_log.size()), 32'd8);
        for (int i = 0; i < ack_log.size(); i++) checkOutput("t3_grant_order", 32'(ack_log[i]), 32'(i % 2));

        // Test 4: stall held through the count plus five cycles delays ack by exactly five.
        stall_req = WR_LAT + 5 - 1;
        s0 = strobe_count;
        applyStimulus(0, 1'b1, 32'h24, 32'h0BADF00D, 4'h3, lat0);
        stall_req = 0;
        checkOutput("t4_stall_latency", 32'(lat0), 32'(2 + WR_LAT + 5));
        checkOutput("t4_no_reissue", 32'(strobe_count - s0), 32'd1);

        // Test 5: reset during WAIT aborts without ack; tie afterwards goes to p0.
        @(posedge clk); #1;
        pend[0] = '{we: 1'b1, addr: 32'h30, wdata: 32'hCAFEF00D, mask: 4'hF};
        pend_v[0] = 1'b1;
        shadow[8'h30] = 32'hCAFEF00D;
        tb_if.p0_we = 1'b1; tb_if.p0_addr = 32'h30; tb_if.p0_wdata = 32'hCAFEF00D; tb_if.p0_sign_mask = 4'hF;
        tb_if.p0_req = 1'b1;
        a0 = ack_log.size();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("t5_busy_in_wait", 32'(busy), 32'd1);
        reset_n = 1'b0;
        tb_if.p0_req = 1'b0;
        @(posedge clk); #1;
        checkOutput("t5_busy_after_reset", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_no_ack", 32'(ack_log.size() - a0), 32'd0);
        ack_log.delete();
        fork
            applyStimulus(0, 1'b0, 32'h34, 32'h0, 4'h0, lat0);
            applyStimulus(1, 1'b0, 32'hB4, 32'h0, 4'h0, lat1);
        join
        checkOutput("t5_tie_after_reset", 32'(ack_log[0]), 32'd0);

        // Test 6: p1 pulses req for one cycle while p0 owns memory.
        a0 = p1_ack_count;
        fork
            applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'h4, lat0);
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                tb_if.p1_we = 1'b0; tb_if.p1_addr = 32'hC0; tb_if.p1_req = 1'b1;
                @(posedge clk); #1;
                tb_if.p1_req = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t6_p0_latency", 32'(lat0), 32'(2 + RD_LAT));
        checkOutput("t6_p1_never_acked", 32'(p1_ack_count - a0), 32'd0);
        checkOutput("t6_idle", 32'(busy), 32'd0);

        // Randomized traffic: disjoint address halves keep per-port expectations independent.
        rand_stall = 1'b1;
        fork
            begin
                int rl0;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    applyStimulus(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)) << 2,
                                  $urandom, 4'($urandom_range(0, 15)), rl0);
                end
            end
            begin
                int rl1;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    applyStimulus(1, 1'($urandom_range(0, 1)), 32'h80 | (32'($urandom_range(0, 31)) << 2),
                                  $urandom, 4'($urandom_range(0, 15)), rl1);
                end
            end
        join
        rand_stall = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("final_p0_queue_empty", 32'(exp_q0.size()), 32'd0);
        checkOutput("final_p1_queue_empty", 32'(exp_q1.size()), 32'd0);
        checkOutput("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
